// File: rtl/tdm_demux8_pkg.sv
// Shared types and constants for the eight-slot TDM demultiplexer.
package tdm_pkg;

    localparam int SLOTS = 8;

    typedef logic [2:0] slot_t;

    typedef enum logic {HUNT, RUN} tdm_state_t;

endpackage

// File: rtl/tdm_demux8_slot_ctr.sv
// Slot counter for the TDM demultiplexer: advances on every accepted beat,
// jumps to 1 on a sync beat (that beat itself occupies slot 0), clears on rst.
// The 7 -> 0 wrap is plain 3-bit overflow.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  load1,
    output slot_t slot
);

    slot_t slot_q;
    slot_t slot_d;

    // Next slot: hold, reload past a sync beat, or advance with natural wrap.
    always_comb begin
        slot_d = slot_q;
        if (en) begin
            slot_d = load1 ? slot_t'(1) : slot_q + slot_t'(1);
        end
    end

    // Slot register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/tdm_demux8.sv
// Eight-slot TDM demultiplexer. Collects slot-serialised beats into shadow
// registers and publishes all eight channel words at once, on the slot-7 beat,
// so the y outputs never show a mix of two frames.
// Optional feature: define TDM_DEMUX_ERRCNT_EN to add the saturating err_cnt
// sync-error counter port.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         frame_sync,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [W-1:0] y4,
    output logic [W-1:0] y5,
    output logic [W-1:0] y6,
    output logic [W-1:0] y7,
    output logic         frame_valid,
    output logic         sync_err,
    output logic         locked,
    output logic [2:0]   slot
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    tdm_state_t state_q;
    tdm_state_t state_d;

    slot_t      slot_cur;
    logic       beat_acc;
    logic       misplaced;
    logic       frame_done;
    slot_t      wr_idx;

    // Slot 7 never needs a shadow: its beat goes straight to y7.
    logic [W-1:0] shadow_q [SLOTS-1];
    logic [W-1:0] shadow_d [SLOTS-1];

    logic [W-1:0] y_q [SLOTS];
    logic [W-1:0] y_d [SLOTS];

    logic frame_valid_q;
    logic frame_valid_d;
    logic sync_err_q;
    logic sync_err_d;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (beat_acc),
        .load1 (frame_sync),
        .slot  (slot_cur)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave HUNT on the first valid sync beat; RUN is sticky.
    always_comb begin
        state_d = state_q;
        if (state_q == HUNT && din_valid && frame_sync) begin
            state_d = RUN;
        end
    end

    // FSM outputs: beat acceptance, misplaced-sync and frame-complete decode.
    always_comb begin
        locked     = (state_q == RUN);
        beat_acc   = din_valid && (state_q == RUN || frame_sync);
        misplaced  = din_valid && frame_sync && (state_q == RUN) && (slot_cur != '0);
        frame_done = din_valid && !frame_sync && (state_q == RUN) && (slot_cur == slot_t'(SLOTS - 1));
        wr_idx     = frame_sync ? slot_t'(0) : slot_cur;
    end

    // Shadow capture of slots 0..6; a sync beat always lands in slot 0.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < SLOTS - 1; i++) begin
            if (beat_acc && wr_idx == slot_t'(i)) begin
                shadow_d[i] = din;
            end
        end
    end

    // Shadow registers need no reset: a fresh frame always rewrites them.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    // Publish a whole frame on the slot-7 beat; flag a misplaced sync.
    always_comb begin
        y_d           = y_q;
        frame_valid_d = 1'b0;
        sync_err_d    = misplaced;
        if (frame_done) begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                y_d[i] = shadow_q[i];
            end
            y_d[SLOTS-1]  = din;
            frame_valid_d = 1'b1;
        end
    end

    // Output and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                y_q[i] <= '0;
            end
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic [7:0] err_cnt_d;

    // Sync-error counter, saturating at 255, cleared only by rst.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (misplaced && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign y0          = y_q[0];
    assign y1          = y_q[1];
    assign y2          = y_q[2];
    assign y3          = y_q[3];
    assign y4          = y_q[4];
    assign y5          = y_q[5];
    assign y6          = y_q[6];
    assign y7          = y_q[7];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_cur;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8 (W=8).
module tb_tdm_demux8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic         frame_valid;
    logic         sync_err;
    logic         locked;
    logic [2:0]   slot;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]   err_cnt;
`endif

    logic [W-1:0] yv [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_demux8 #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .y4          (y4),
        .y5          (y5),
        .y6          (y6),
        .y7          (y7),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked),
        .slot        (slot)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;
    assign yv[3] = y3;
    assign yv[4] = y4;
    assign yv[5] = y5;
    assign yv[6] = y6;
    assign yv[7] = y7;

    // Advance one clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic fs);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = fs;
        tick();
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 8'hFF; din_valid = 1'b1; frame_sync = 1'b1;
        tick();
        tick();
        rst = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (yv[i] !== 8'h00) begin
                errors++; $display("FAIL reset_y%0d got %h expected 00", i, yv[i]);
            end
        end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b expected 0", locked); end
        checks++;
        if (slot !== 3'd0) begin errors++; $display("FAIL reset_slot got %0d expected 0", slot); end
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b expected 0", frame_valid); end
        checks++;
        if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b expected 0", sync_err); end
    endtask

    task automatic test_pre_sync();
        for (int i = 0; i < 5; i++) begin
            beat(8'h01 + 8'(i), 1'b0);
            checks++;
            if (locked !== 1'b0 || slot !== 3'd0) begin
                errors++; $display("FAIL presync_beat%0d locked=%b slot=%0d expected locked=0 slot=0", i, locked, slot);
            end
        end
        beat(8'h10, 1'b1);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL presync_lock got %b expected 1", locked); end
        checks++;
        if (slot !== 3'd1) begin errors++; $display("FAIL presync_slot got %0d expected 1", slot); end
    endtask

    // Continues the frame started by test_pre_sync (slot 0 = 0x10).
    task automatic test_clean_frame();
        for (int i = 1; i < 8; i++) begin
            beat(8'h10 + 8'(i), 1'b0);
            if (i < 7) begin
                checks++;
                if (frame_valid !== 1'b0) begin errors++; $display("FAIL clean_early_fv slot%0d got %b expected 0", i, frame_valid); end
                checks++;
                if (slot !== 3'(i + 1)) begin errors++; $display("FAIL clean_slot got %0d expected %0d", slot, i + 1); end
            end
        end
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL clean_fv got %b expected 1", frame_valid); end
        checks++;
        if (slot !== 3'd0) begin errors++; $display("FAIL clean_wrap_slot got %0d expected 0", slot); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (yv[i] !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL clean_y%0d got %h expected %h", i, yv[i], 8'h10 + 8'(i));
            end
        end
        tick();
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL clean_fv_pulse got %b expected 0", frame_valid); end
        checks++;
        if (y0 !== 8'h10 || y7 !== 8'h17) begin errors++; $display("FAIL clean_hold got y0=%h y7=%h expected 10/17", y0, y7); end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 8; i++) begin
            beat(8'h20 + 8'(i), i == 0);
            if (i == 2) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    checks++;
                    if (slot !== 3'd3 || frame_valid !== 1'b0) begin
                        errors++; $display("FAIL gap%0d slot=%0d fv=%b expected slot=3 fv=0", g, slot, frame_valid);
                    end
                    for (int k = 0; k < 8; k++) begin
                        checks++;
                        if (yv[k] !== 8'h10 + 8'(k)) begin
                            errors++; $display("FAIL gap_hold_y%0d got %h expected %h", k, yv[k], 8'h10 + 8'(k));
                        end
                    end
                end
            end
        end
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL gapped_fv got %b expected 1", frame_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (yv[i] !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL gapped_y%0d got %h expected %h", i, yv[i], 8'h20 + 8'(i));
            end
        end
    endtask

    task automatic test_misplaced();
        for (int i = 0; i < 4; i++) beat(8'h30 + 8'(i), i == 0);
        checks++;
        if (slot !== 3'd4) begin errors++; $display("FAIL mis_pre_slot got %0d expected 4", slot); end
        beat(8'hA0, 1'b1);
        checks++;
        if (sync_err !== 1'b1) begin errors++; $display("FAIL mis_sync_err got %b expected 1", sync_err); end
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL mis_fv got %b expected 0", frame_valid); end
        checks++;
        if (slot !== 3'd1 || locked !== 1'b1) begin errors++; $display("FAIL mis_slot_lock slot=%0d locked=%b expected 1/1", slot, locked); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (yv[i] !== 8'h20 + 8'(i)) begin
                errors++; $display("FAIL mis_hold_y%0d got %h expected %h", i, yv[i], 8'h20 + 8'(i));
            end
        end
        for (int i = 1; i < 8; i++) begin
            beat(8'hA0 + 8'(i), 1'b0);
            if (i == 1) begin
                checks++;
                if (sync_err !== 1'b0) begin errors++; $display("FAIL mis_sync_err_pulse got %b expected 0", sync_err); end
            end
        end
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL mis_next_fv got %b expected 1", frame_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (yv[i] !== 8'hA0 + 8'(i)) begin
                errors++; $display("FAIL mis_next_y%0d got %h expected %h", i, yv[i], 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 0; i < 24; i++) begin
            beat(8'h40 + 8'(i), (i == 0) || (i == 16));
            if (frame_valid === 1'b1) pulses++;
            checks++;
            if (frame_valid !== ((i % 8) == 7)) begin
                errors++; $display("FAIL b2b_fv beat%0d got %b expected %b", i, frame_valid, (i % 8) == 7);
            end
            checks++;
            if (sync_err !== 1'b0) begin errors++; $display("FAIL b2b_sync_err beat%0d got %b expected 0", i, sync_err); end
        end
        checks++;
        if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d expected 3", pulses); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (yv[i] !== 8'h50 + 8'(i)) begin
                errors++; $display("FAIL b2b_y%0d got %h expected %h", i, yv[i], 8'h50 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) beat(8'h60 + 8'(i), i == 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (locked !== 1'b0 || slot !== 3'd0 || frame_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl locked=%b slot=%0d fv=%b expected 0/0/0", locked, slot, frame_valid);
        end
        checks++;
        if (y0 !== 8'h00 || y7 !== 8'h00) begin errors++; $display("FAIL midrst_y got y0=%h y7=%h expected 00/00", y0, y7); end
        for (int i = 4; i < 8; i++) begin
            beat(8'h60 + 8'(i), 1'b0);
            checks++;
            if (locked !== 1'b0 || frame_valid !== 1'b0 || slot !== 3'd0) begin
                errors++; $display("FAIL midrst_tail beat%0d locked=%b fv=%b slot=%0d expected 0/0/0", i, locked, frame_valid, slot);
            end
        end
        for (int i = 0; i < 8; i++) beat(8'h70 + 8'(i), i == 0);
        checks++;
        if (frame_valid !== 1'b1 || y0 !== 8'h70 || y7 !== 8'h77) begin
            errors++; $display("FAIL midrst_relock fv=%b y0=%h y7=%h expected 1/70/77", frame_valid, y0, y7);
        end
    endtask

`ifdef TDM_DEMUX_ERRCNT_EN
    task automatic test_errcnt();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL errcnt_reset got %0d expected 0", err_cnt); end
        beat(8'h00, 1'b1);
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL errcnt_first_sync got %0d expected 0", err_cnt); end
        for (int i = 0; i < 260; i++) begin
            beat(8'(i), 1'b1);
            if (i == 4) begin
                checks++;
                if (err_cnt !== 8'd5) begin errors++; $display("FAIL errcnt_5 got %0d expected 5", err_cnt); end
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("FAIL errcnt_sat got %0d expected 255", err_cnt); end
        repeat (2) tick();
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("FAIL errcnt_hold got %0d expected 255", err_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL errcnt_clear got %0d expected 0", err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_pre_sync();
        test_clean_frame();
        test_gapped();
        test_misplaced();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef TDM_DEMUX_ERRCNT_EN
        test_errcnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

- Eight-slot time-division demultiplexer; the receive-side counterpart of the team's 8:1 channel mux.
- Accepts a slot-serialised stream, one W-bit beat per slot, with a frame-sync marker on slot 0.
- Rebuilds the eight channel words and presents all eight together on registered outputs, with a one-cycle frame strobe.
- Sits at the far end of a shared link, feeding per-channel consumers.

## Interface
Parameters:
- W, 1, width of one slot/channel word

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  W  slot data beat
- din_valid  input  1  beat present this cycle
- frame_sync  input  1  marks the current beat as slot 0; ignored when din_valid=0
- y0 … y7  output  W each  channel words, held between frames
- frame_valid  output  1  one-cycle strobe: y0..y7 just updated with a complete frame
- sync_err  output  1  one-cycle strobe: frame_sync arrived at a slot other than 0
- locked  output  1  high in RUN state
- slot  output  3  index the next accepted beat will occupy
- err_cnt  output  8  sync-error count (only with TDM_DEMUX_ERRCNT_EN)

Clock and reset: one clock (clk); reset rst is synchronous and active-high.

## Operation
- **State machine.** States are HUNT and RUN.
- **Reset.** Forces state HUNT, slot=0, y0..y7=0, frame_valid=0, sync_err=0, err_cnt=0.
- **HUNT.** Beats without frame_sync are dropped. A beat with din_valid & frame_sync is captured as slot 0; state goes to RUN and slot becomes 1.
- **RUN, normal beat.** Each din_valid beat is captured into shadow[slot], then slot increments.
  - frame_sync on a slot-0 beat is normal.
  - Absence of frame_sync at slot 0 is permitted (free-running).
- **Gaps.** din_valid=0 holds slot, shadow and outputs; any number of gap cycles is allowed mid-frame.
- **Slot-7 beat.** At that edge, y0..y6 <= shadow[0..6], y7 <= din, frame_valid <= 1, slot wraps to 0. Outputs never show a mixed frame.
- **Misplaced sync.** frame_sync on a valid beat in RUN with slot≠0:
  - sync_err <= 1 for one cycle.
  - The partial frame is discarded: no frame_valid, y unchanged.
  - The beat is captured as slot 0, and slot becomes 1.
  - State stays RUN.
- **Width.** slot is 3 bits unsigned; wrap 7→0 is natural overflow.
- **Reset mid-frame.** Discards the shadow contents and returns to HUNT; no frame_valid is issued.

## Timing
- din, din_valid and frame_sync are sampled on the rising edge of clk.
- Latency: slot-7 beat sampled at edge N → y0..y7 updated and frame_valid high during cycle N+1.
- frame_valid and sync_err are single-cycle registered pulses.
- Back-to-back frames with no gaps give one frame_valid every 8 cycles.
- locked rises the cycle after the first sync beat is accepted; slot is registered.
- No backpressure: every valid beat is consumed.

## Configuration
- **TDM_DEMUX_ERRCNT_EN defined.**
  - err_cnt is present: 8-bit counter, +1 on each sync_err, saturating at 255.
  - Cleared only by rst.
- **Not defined.** err_cnt port and logic are absent; all other behaviour is identical.

## Structure
- **Package tdm_pkg:**
  - localparam SLOTS=8
  - typedef logic [2:0] slot_t
  - typedef enum {HUNT, RUN} tdm_state_t
- **Sub-module tdm_slot_ctr:** 3-bit slot counter with enable (din_valid), load-to-1 (sync beat) and clear (rst); instantiated once.
- Top level: FSM, shadow registers, output registers, optional error counter.

## Test plan
- **Reset.** Reset, then 3 cycles idle → y0..y7=0, locked=0, slot=0, frame_valid=0.
- **Clean frame, W=8.** Beats 0x10..0x17, frame_sync on the first → one cycle after 0x17: y0=0x10 … y7=0x17, frame_valid high for exactly 1 cycle, slot=0.
- **Pre-sync data.** 5 beats without frame_sync before the first sync → ignored; locked stays 0 until the sync beat.
- **Gapped frame.** Same frame with din_valid low 3 cycles after slot 2 → identical outputs; frame_valid delayed by 3 cycles; y holds the previous frame during the gaps.
- **Misplaced sync.** frame_sync at slot 4 → sync_err 1 cycle, no frame_valid, y unchanged. The next 8 beats (0xA0..0xA7) yield y0=0xA0 … y7=0xA7.
- **Error-count saturation (ERRCNT_EN).** 260 misplaced syncs → err_cnt=255, holds; rst → 0.
